// File: rtl/nr_divider_pkg.sv
// Shared types and helpers for the non-restoring divider.
// Operand widths up to MAX_W are supported by the helpers below.
package div_pkg;

   localparam int MAX_W = 64;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FIX,
      DONE
   } div_state_e;

   // Callers truncate this to their own WIDTH.
   localparam logic [MAX_W-1:0] DBZ_QUOTIENT = '1;

   // Two's-complement conditional negation.
   // Used both for operand magnitudes and for applying result signs.
   function automatic logic [MAX_W-1:0] cond_negate(input logic [MAX_W-1:0] value,
                                                    input logic             negate);
      return negate ? (~value + 1'b1) : value;
   endfunction

endpackage

// File: rtl/nr_divider_if.sv
// Request/response bundle between a datapath master and the divider.
interface nr_divider_if #(
   parameter int WIDTH = 32
) ();

   logic             start;
   logic             signed_op;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   modport master (
      output start, signed_op, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, signed_op, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );

endinterface

// File: rtl/nr_div_step.sv
// One non-restoring iteration: shift {A,Q} left, then add or subtract M
// according to the sign A had before the shift.
module nr_div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0]   a_in,
   input  logic [WIDTH-1:0] q_in,
   input  logic [WIDTH-1:0] m_in,
   output logic [WIDTH:0]   a_out,
   output logic [WIDTH-1:0] q_out
);

   logic [WIDTH:0] a_shift;
   logic [WIDTH:0] a_next;

   // A may wrap mid-step; the add/sub result is exact modulo 2^(WIDTH+1).
   always_comb begin
      a_shift = {a_in[WIDTH-1:0], q_in[WIDTH-1]};
      if (a_in[WIDTH]) begin
         a_next = a_shift + {1'b0, m_in};
      end else begin
         a_next = a_shift - {1'b0, m_in};
      end
      a_out = a_next;
      q_out = {q_in[WIDTH-2:0], ~a_next[WIDTH]};
   end

endmodule

// File: rtl/nr_divider.sv
// Sequential signed/unsigned non-restoring divider with start/done handshake.
// Divides magnitudes, then applies the quotient and remainder signs in FIX.
module nr_divider
   import div_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic        clk,
   input  logic        reset,
   nr_divider_if.slave bus
);

   localparam int            CW         = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

   div_state_e       state_q, state_d;
   logic [WIDTH:0]   a_q, a_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] m_q, m_d;
   logic [CW-1:0]    count_q, count_d;
   logic             neg_quo_q, neg_quo_d;
   logic             neg_rem_q, neg_rem_d;
   logic             dbz_q, dbz_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] quotient_q, quotient_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;
   logic             div_by_zero_q, div_by_zero_d;

   logic [WIDTH:0]   step_a;
   logic [WIDTH-1:0] step_q;
   logic [WIDTH-1:0] a_fix;

   nr_div_step #(.WIDTH(WIDTH)) u_step (
      .a_in  (a_q),
      .q_in  (q_q),
      .m_in  (m_q),
      .a_out (step_a),
      .q_out (step_q)
   );

   always_comb begin
      state_d       = state_q;
      a_d           = a_q;
      q_d           = q_q;
      m_d           = m_q;
      count_d       = count_q;
      neg_quo_d     = neg_quo_q;
      neg_rem_d     = neg_rem_q;
      dbz_d         = dbz_q;
      quotient_d    = quotient_q;
      remainder_d   = remainder_q;
      div_by_zero_d = div_by_zero_q;
      busy_d        = (state_q != IDLE);
      done_d        = (state_q == DONE);
      a_fix         = a_q[WIDTH] ? (a_q[WIDTH-1:0] + m_q) : a_q[WIDTH-1:0];

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               neg_quo_d = bus.signed_op & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
               neg_rem_d = bus.signed_op & bus.dividend[WIDTH-1];
               a_d       = '0;
               q_d       = WIDTH'(cond_negate(MAX_W'(bus.dividend),
                                              bus.signed_op & bus.dividend[WIDTH-1]));
               m_d       = WIDTH'(cond_negate(MAX_W'(bus.divisor),
                                              bus.signed_op & bus.divisor[WIDTH-1]));
               count_d   = '0;
               dbz_d     = (bus.divisor == '0);
               state_d   = (bus.divisor == '0) ? FIX : RUN;
            end
         end

         RUN: begin
            a_d     = step_a;
            q_d     = step_q;
            count_d = count_q + 1'b1;
            if (count_q == LAST_COUNT) begin
               state_d = FIX;
            end
         end

         // On divide-by-zero Q still holds |dividend|, so re-signing it
         // reproduces the dividend exactly as it was sampled.
         FIX: begin
            if (dbz_q) begin
               q_d = WIDTH'(DBZ_QUOTIENT);
               a_d = {1'b0, WIDTH'(cond_negate(MAX_W'(q_q), neg_rem_q))};
            end else begin
               q_d = WIDTH'(cond_negate(MAX_W'(q_q), neg_quo_q));
               a_d = {1'b0, WIDTH'(cond_negate(MAX_W'(a_fix), neg_rem_q))};
            end
            state_d = DONE;
         end

         DONE: begin
            quotient_d    = q_q;
            remainder_d   = a_q[WIDTH-1:0];
            div_by_zero_d = dbz_q;
            state_d       = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         a_q           <= '0;
         q_q           <= '0;
         m_q           <= '0;
         count_q       <= '0;
         neg_quo_q     <= 1'b0;
         neg_rem_q     <= 1'b0;
         dbz_q         <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         quotient_q    <= '0;
         remainder_q   <= '0;
         div_by_zero_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         a_q           <= a_d;
         q_q           <= q_d;
         m_q           <= m_d;
         count_q       <= count_d;
         neg_quo_q     <= neg_quo_d;
         neg_rem_q     <= neg_rem_d;
         dbz_q         <= dbz_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         quotient_q    <= quotient_d;
         remainder_q   <= remainder_d;
         div_by_zero_q <= div_by_zero_d;
      end
   end

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.quotient    = quotient_q;
   assign bus.remainder   = remainder_q;
   assign bus.div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_nr_divider.sv
// Self-checking bench for nr_divider at WIDTH=32 and WIDTH=8, using a
// plain-arithmetic truncating-division reference model.
module tb_nr_divider;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   nr_divider_if #(.WIDTH(32)) bus32 ();
   nr_divider_if #(.WIDTH(8))  bus8 ();

   nr_divider #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32));
   nr_divider #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(bus8));

   int checks = 0;
   int passes = 0;

   // Truncating division: quotient rounds toward zero, remainder takes the dividend's sign.
   function automatic void ref_div(input int w, input bit s,
                                   input longint unsigned dvd, input longint unsigned dvs,
                                   output longint unsigned q, output longint unsigned r,
                                   output bit z);
      longint unsigned mask;
      longint          a;
      longint          b;
      mask = (64'd1 << w) - 64'd1;
      if (dvs == 0) begin
         q = mask;
         r = dvd;
         z = 1'b1;
         return;
      end
      a = $signed(dvd);
      b = $signed(dvs);
      if (s && dvd[w-1]) a = a - ($signed(64'd1) << w);
      if (s && dvs[w-1]) b = b - ($signed(64'd1) << w);
      q = $unsigned(a / b) & mask;
      r = $unsigned(a % b) & mask;
      z = 1'b0;
   endfunction

   task automatic issue32(input bit s, input logic [31:0] dvd, input logic [31:0] dvs,
                          output int lat, output int busy_n, output int done_n);
      @(negedge clk);
      bus32.start = 1'b1; bus32.signed_op = s; bus32.dividend = dvd; bus32.divisor = dvs;
      @(posedge clk); #1;
      bus32.start = 1'b0; bus32.signed_op = ~s;
      bus32.dividend = $urandom; bus32.divisor = $urandom;
      lat = -1;
      busy_n = int'(bus32.busy);
      done_n = int'(bus32.done);
      for (int e = 1; e <= 120; e++) begin
         @(posedge clk); #1;
         busy_n += int'(bus32.busy);
         done_n += int'(bus32.done);
         if (bus32.done && lat < 0) lat = e;
         if (lat >= 0 && e == lat + 1) break;
      end
   endtask

   task automatic issue8(input bit s, input logic [7:0] dvd, input logic [7:0] dvs,
                         output int lat, output int done_n);
      @(negedge clk);
      bus8.start = 1'b1; bus8.signed_op = s; bus8.dividend = dvd; bus8.divisor = dvs;
      @(posedge clk); #1;
      bus8.start = 1'b0; bus8.dividend = 8'($urandom); bus8.divisor = 8'($urandom);
      lat = -1;
      done_n = int'(bus8.done);
      for (int e = 1; e <= 60; e++) begin
         @(posedge clk); #1;
         done_n += int'(bus8.done);
         if (bus8.done && lat < 0) lat = e;
         if (lat >= 0 && e == lat + 1) break;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (bus32.busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", bus32.busy); else passes++;
      checks++; if (bus32.done !== 1'b0) $display("[TB] FAIL reset_done: got %b want 0", bus32.done); else passes++;
      checks++; if (bus32.quotient !== 32'd0) $display("[TB] FAIL reset_q: got %h want 0", bus32.quotient); else passes++;
      checks++; if (bus32.remainder !== 32'd0) $display("[TB] FAIL reset_r: got %h want 0", bus32.remainder); else passes++;
      checks++; if (bus32.div_by_zero !== 1'b0) $display("[TB] FAIL reset_dbz: got %b want 0", bus32.div_by_zero); else passes++;
      checks++;
      if ({bus8.busy, bus8.done, bus8.quotient, bus8.remainder, bus8.div_by_zero} !== 19'd0)
         $display("[TB] FAIL reset_w8: got %h want 0", {bus8.busy, bus8.done, bus8.quotient, bus8.remainder, bus8.div_by_zero});
      else passes++;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_directed32();
      bit          s_tbl [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      logic [31:0] a_tbl [9] = '{32'd38, 32'hFFFFFFDA, 32'd38, 32'hFFFFFFDA, 32'h80000000,
                                 32'hFFFFFFFF, 32'd100, 32'd100, 32'd7};
      logic [31:0] b_tbl [9] = '{32'd6, 32'd6, 32'hFFFFFFFA, 32'hFFFFFFFA, 32'hFFFFFFFF,
                                 32'd2, 32'd0, 32'd0, 32'd7};
      longint unsigned eq, er;
      bit ez;
      int lat, busy_n, done_n, want_lat;
      for (int i = 0; i < 9; i++) begin
         issue32(s_tbl[i], a_tbl[i], b_tbl[i], lat, busy_n, done_n);
         ref_div(32, s_tbl[i], a_tbl[i], b_tbl[i], eq, er, ez);
         want_lat = ez ? 2 : 34;
         checks++; if (bus32.quotient !== eq[31:0]) $display("[TB] FAIL dir%0d_q: got %h want %h", i, bus32.quotient, eq[31:0]); else passes++;
         checks++; if (bus32.remainder !== er[31:0]) $display("[TB] FAIL dir%0d_r: got %h want %h", i, bus32.remainder, er[31:0]); else passes++;
         checks++; if (bus32.div_by_zero !== ez) $display("[TB] FAIL dir%0d_dbz: got %b want %b", i, bus32.div_by_zero, ez); else passes++;
         checks++; if (lat !== want_lat) $display("[TB] FAIL dir%0d_latency: got %0d want %0d", i, lat, want_lat); else passes++;
         checks++; if (busy_n !== want_lat) $display("[TB] FAIL dir%0d_busy_cycles: got %0d want %0d", i, busy_n, want_lat); else passes++;
         checks++; if (done_n !== 1) $display("[TB] FAIL dir%0d_done_pulses: got %0d want 1", i, done_n); else passes++;
      end
   endtask

   task automatic test_random32();
      longint unsigned eq, er;
      bit ez, s;
      logic [31:0] a, b;
      int lat, busy_n, done_n, sel;
      for (int i = 0; i < 30; i++) begin
         s   = 1'($urandom);
         a   = $urandom;
         sel = int'($urandom_range(0, 7));
         case (sel)
            0:       b = 32'd0;
            1:       b = $urandom_range(1, 15);
            2:       b = 32'hFFFFFFFF;
            3:       b = 32'h80000000;
            default: b = $urandom;
         endcase
         issue32(s, a, b, lat, busy_n, done_n);
         ref_div(32, s, a, b, eq, er, ez);
         checks++;
         if ({bus32.quotient, bus32.remainder, bus32.div_by_zero} !== {eq[31:0], er[31:0], ez})
            $display("[TB] FAIL rnd%0d %s %h/%h: got q=%h r=%h z=%b want q=%h r=%h z=%b",
                     i, s ? "s" : "u", a, b, bus32.quotient, bus32.remainder, bus32.div_by_zero,
                     eq[31:0], er[31:0], ez);
         else passes++;
         checks++; if (lat !== (ez ? 2 : 34)) $display("[TB] FAIL rnd%0d_latency: got %0d want %0d", i, lat, ez ? 2 : 34); else passes++;
      end
   endtask

   task automatic test_ignore_start();
      int lat, done_n;
      @(negedge clk);
      bus32.start = 1'b1; bus32.signed_op = 1'b0; bus32.dividend = 32'd20; bus32.divisor = 32'd3;
      @(posedge clk); #1;
      bus32.start = 1'b0;
      lat = -1;
      done_n = 0;
      for (int e = 1; e <= 80; e++) begin
         if (e == 3 || e == 4 || e == 17 || e == 33 || e == 34) begin
            bus32.start = 1'b1; bus32.signed_op = 1'($urandom);
            bus32.dividend = $urandom; bus32.divisor = $urandom_range(1, 9);
         end else begin
            bus32.start = 1'b0;
         end
         @(posedge clk); #1;
         done_n += int'(bus32.done);
         if (bus32.done && lat < 0) lat = e;
         if (lat >= 0 && e == lat + 5) break;
      end
      bus32.start = 1'b0;
      checks++; if (bus32.quotient !== 32'd6) $display("[TB] FAIL ign_q: got %h want 6", bus32.quotient); else passes++;
      checks++; if (bus32.remainder !== 32'd2) $display("[TB] FAIL ign_r: got %h want 2", bus32.remainder); else passes++;
      checks++; if (lat !== 34) $display("[TB] FAIL ign_latency: got %0d want 34", lat); else passes++;
      checks++; if (done_n !== 1) $display("[TB] FAIL ign_done_pulses: got %0d want 1", done_n); else passes++;
      checks++; if (bus32.busy !== 1'b0) $display("[TB] FAIL ign_busy_after: got %b want 0", bus32.busy); else passes++;
   endtask

   task automatic test_reset_mid();
      int lat, busy_n, done_n;
      @(negedge clk);
      bus32.start = 1'b1; bus32.signed_op = 1'b0; bus32.dividend = 32'd50000; bus32.divisor = 32'd3;
      @(posedge clk); #1;
      bus32.start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      checks++; if (bus32.busy !== 1'b1) $display("[TB] FAIL mid_busy_before: got %b want 1", bus32.busy); else passes++;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      checks++;
      if ({bus32.busy, bus32.done, bus32.quotient, bus32.remainder, bus32.div_by_zero} !== 67'd0)
         $display("[TB] FAIL mid_reset_outputs: got busy=%b done=%b q=%h r=%h z=%b want all 0",
                  bus32.busy, bus32.done, bus32.quotient, bus32.remainder, bus32.div_by_zero);
      else passes++;
      done_n = 0;
      for (int e = 0; e < 40; e++) begin
         @(posedge clk); #1;
         done_n += int'(bus32.done);
      end
      checks++; if (done_n !== 0) $display("[TB] FAIL mid_stray_done: got %0d want 0", done_n); else passes++;
      issue32(1'b0, 32'd9, 32'd4, lat, busy_n, done_n);
      checks++; if (bus32.quotient !== 32'd2) $display("[TB] FAIL mid_q: got %h want 2", bus32.quotient); else passes++;
      checks++; if (bus32.remainder !== 32'd1) $display("[TB] FAIL mid_r: got %h want 1", bus32.remainder); else passes++;
      checks++; if (lat !== 34) $display("[TB] FAIL mid_latency: got %0d want 34", lat); else passes++;
   endtask

   task automatic test_back_to_back();
      int lat1, lat2;
      @(negedge clk);
      bus32.start = 1'b1; bus32.signed_op = 1'b0; bus32.dividend = 32'd12; bus32.divisor = 32'd5;
      @(posedge clk); #1;
      bus32.start = 1'b0;
      lat1 = -1;
      for (int e = 1; e <= 60; e++) begin
         @(posedge clk); #1;
         if (bus32.done) begin
            lat1 = e;
            break;
         end
      end
      checks++; if (lat1 !== 34) $display("[TB] FAIL b2b_latency1: got %0d want 34", lat1); else passes++;
      checks++; if ({bus32.quotient, bus32.remainder} !== {32'd2, 32'd2}) $display("[TB] FAIL b2b_first: got q=%h r=%h want q=2 r=2", bus32.quotient, bus32.remainder); else passes++;
      bus32.start = 1'b1; bus32.signed_op = 1'b0; bus32.dividend = 32'd100; bus32.divisor = 32'd9;
      @(posedge clk); #1;
      bus32.start = 1'b0;
      lat2 = -1;
      for (int e = 1; e <= 60; e++) begin
         @(posedge clk); #1;
         if (bus32.done) begin
            lat2 = e;
            break;
         end
      end
      checks++; if (lat2 !== 34) $display("[TB] FAIL b2b_latency2: got %0d want 34", lat2); else passes++;
      checks++; if ({bus32.quotient, bus32.remainder} !== {32'd11, 32'd1}) $display("[TB] FAIL b2b_second: got q=%h r=%h want q=b r=1", bus32.quotient, bus32.remainder); else passes++;
      @(posedge clk); #1;
   endtask

   task automatic test_width8();
      longint unsigned eq, er;
      bit ez, s;
      logic [7:0] a, b;
      int lat, done_n;
      issue8(1'b0, 8'd200, 8'd7, lat, done_n);
      checks++; if ({bus8.quotient, bus8.remainder} !== {8'd28, 8'd4}) $display("[TB] FAIL w8_200_7: got q=%h r=%h want q=1c r=04", bus8.quotient, bus8.remainder); else passes++;
      checks++; if (lat !== 10) $display("[TB] FAIL w8_latency: got %0d want 10", lat); else passes++;
      checks++; if (done_n !== 1) $display("[TB] FAIL w8_done_pulses: got %0d want 1", done_n); else passes++;
      issue8(1'b1, 8'h80, 8'd3, lat, done_n);
      checks++; if ({bus8.quotient, bus8.remainder} !== {8'hD6, 8'hFE}) $display("[TB] FAIL w8_m128_3: got q=%h r=%h want q=d6 r=fe", bus8.quotient, bus8.remainder); else passes++;
      for (int i = 0; i < 25; i++) begin
         s = 1'($urandom);
         a = 8'($urandom);
         b = (i % 6 == 0) ? 8'd0 : 8'($urandom);
         issue8(s, a, b, lat, done_n);
         ref_div(8, s, a, b, eq, er, ez);
         checks++;
         if ({bus8.quotient, bus8.remainder, bus8.div_by_zero} !== {eq[7:0], er[7:0], ez})
            $display("[TB] FAIL w8rnd%0d %s %h/%h: got q=%h r=%h z=%b want q=%h r=%h z=%b",
                     i, s ? "s" : "u", a, b, bus8.quotient, bus8.remainder, bus8.div_by_zero,
                     eq[7:0], er[7:0], ez);
         else passes++;
         checks++; if (lat !== (ez ? 2 : 10)) $display("[TB] FAIL w8rnd%0d_latency: got %0d want %0d", i, lat, ez ? 2 : 10); else passes++;
      end
   endtask

   initial begin
      reset = 1'b1;
      bus32.start = 1'b0; bus32.signed_op = 1'b0; bus32.dividend = '0; bus32.divisor = '0;
      bus8.start  = 1'b0; bus8.signed_op  = 1'b0; bus8.dividend  = '0; bus8.divisor  = '0;
      test_reset();
      test_directed32();
      test_random32();
      test_ignore_start();
      test_reset_mid();
      test_back_to_back();
      test_width8();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
